rr_arbiter_4: RTL

Four-requester round-robin arbiter with a bounded hold time. It shares one resource among four masters, e.g. a register-file write port or memory port in the MIPS datapath. The grant is a 2-bit owner index plus its one-hot decode, which is the 2-to-4 decoder function registered inside the block. Each grant is held while its requester keeps requesting, and is pre-empted after MAX_HOLD cycles if another master is waiting.

---
 rtl/rr_arbiter_4.sv | 119 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
//==============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with bounded hold time and
//               registered one-hot / index grant outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [7:0] c_hold_max = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;

    logic [3:0] w_mask;
    logic [1:0] w_start;
    logic [2:0] w_search;
    logic       w_found;
    logic [1:0] w_win;
    logic       w_rel_a;
    logic       w_rel_b;
    logic       w_release;

    // Returns {found, index} of the first set mask bit scanning from start.
    function automatic logic [2:0] f_search(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [3:0] f_decode(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // While granted, only the other three masters compete for the handoff.
    always_comb begin
        w_mask  = req;
        w_start = r_ptr;
        if (r_state == S_GRANT) begin
            w_mask  = req & ~gnt;
            w_start = gnt_idx + 2'd1;
        end
    end

    assign w_search  = f_search(w_mask, w_start);
    assign w_found   = w_search[2];
    assign w_win     = w_search[1:0];
    assign w_rel_a   = ~req[gnt_idx];
    assign w_rel_b   = (r_hold_cnt == c_hold_max) && ((req & ~gnt) != 4'b0000);
    assign w_release = w_rel_a | w_rel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
            gnt        <= 4'b0000;
            gnt_idx    <= 2'd0;
            gnt_valid  <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        gnt_idx    <= w_win;
                        gnt        <= f_decode(w_win);
                        gnt_valid  <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr   <= gnt_idx + 2'd1;
                        preempt <= ~w_rel_a;
                        if (w_found) begin
                            gnt_idx    <= w_win;
                            gnt        <= f_decode(w_win);
                            r_hold_cnt <= 8'd0;
                        end else begin
                            r_state   <= S_IDLE;
                            gnt       <= 4'b0000;
                            gnt_valid <= 1'b0;
                        end
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
